// File: rtl/integral_image_window_writer.sv
// Integral-image window writer: streams a WIN_SIZE x WIN_SIZE pixel window in raster
// order, emits the (WIN_SIZE+1)^2 integral-image words, then starts the cascade and captures its result.
module integral_image_window_writer #(
  parameter int WIN_SIZE      = 20,
  parameter int ADDR_WIDTH_II = $clog2((WIN_SIZE+1)*(WIN_SIZE+1))
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     win_start_i,
  input  logic [7:0]               pix_i,
  input  logic                     pix_val_i,
  output logic                     pix_rdy_o,
  output logic [ADDR_WIDTH_II-1:0] ii_addr_wr_o,
  output logic [31:0]              ii_data_wr_o,
  output logic                     ii_val_wr_o,
  output logic                     cascade_start_o,
  input  logic                     cascade_done_i,
  input  logic                     cascade_result_i,
  output logic [16:0]              sum_o,
  output logic [24:0]              sq_sum_o,
  output logic                     result_o,
  output logic                     result_val_o,
  output logic                     busy_o
);

  localparam int CW = $clog2(WIN_SIZE+1);

  typedef enum logic [2:0] {
    IDLE, ZERO_ROW, ROW_COL0, ROW_PIX, START, WAIT_DONE
  } state_t;

  state_t                   state, state_nxt;
  logic [CW-1:0]            r_cnt, c_cnt;
  logic [ADDR_WIDTH_II-1:0] addr_cnt;
  logic [16:0]              rowsum;
  logic [16:0]              lb [0:WIN_SIZE];
  logic [16:0]              sum_acc;
  logic [24:0]              sq_acc;

  logic                     last_col, last_row;
  logic [16:0]              rowsum_nxt, ii_new;
  logic [15:0]              pix_sq;
  logic                     vld_p0;
  logic [16:0]              data_p0;

  logic                     vld_p1;
  logic [ADDR_WIDTH_II-1:0] addr_p1;
  logic [16:0]              data_p1;
  logic                     start_p1;
  logic                     res_vld_p1;
  logic                     res_p1;

  assign last_col   = (c_cnt == CW'(WIN_SIZE));
  assign last_row   = (r_cnt == CW'(WIN_SIZE));
  assign rowsum_nxt = rowsum + 17'(pix_i);
  // lb[c] still holds ii[r-1][c] until this pixel overwrites it
  assign ii_new     = rowsum_nxt + lb[c_cnt];
  assign pix_sq     = 16'(pix_i) * 16'(pix_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    vld_p0    = 1'b0;
    data_p0   = '0;
    case (state)
      IDLE:      if (win_start_i) state_nxt = ZERO_ROW;
      ZERO_ROW: begin
        vld_p0 = 1'b1;
        if (last_col) state_nxt = ROW_COL0;
      end
      ROW_COL0: begin
        vld_p0    = 1'b1;
        state_nxt = ROW_PIX;
      end
      ROW_PIX: begin
        if (pix_val_i) begin
          vld_p0  = 1'b1;
          data_p0 = ii_new;
          if (last_col) state_nxt = last_row ? START : ROW_COL0;
        end
      end
      START:     state_nxt = WAIT_DONE;
      WAIT_DONE: if (cascade_done_i) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt    <= '0;
      c_cnt    <= '0;
      addr_cnt <= '0;
      rowsum   <= '0;
      sum_acc  <= '0;
      sq_acc   <= '0;
      for (int i = 0; i <= WIN_SIZE; i++) lb[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          c_cnt    <= '0;
          r_cnt    <= '0;
          addr_cnt <= '0;
          if (win_start_i) begin
            sum_acc <= '0;
            sq_acc  <= '0;
          end
        end
        ZERO_ROW: begin
          lb[c_cnt] <= '0;
          addr_cnt  <= addr_cnt + ADDR_WIDTH_II'(1);
          if (last_col) r_cnt <= CW'(1);
          else          c_cnt <= c_cnt + CW'(1);
        end
        ROW_COL0: begin
          rowsum   <= '0;
          c_cnt    <= CW'(1);
          addr_cnt <= addr_cnt + ADDR_WIDTH_II'(1);
        end
        ROW_PIX: begin
          if (pix_val_i) begin
            rowsum    <= rowsum_nxt;
            lb[c_cnt] <= ii_new;
            sum_acc   <= sum_acc + 17'(pix_i);
            sq_acc    <= sq_acc + 25'(pix_sq);
            addr_cnt  <= addr_cnt + ADDR_WIDTH_II'(1);
            if (!last_col)     c_cnt <= c_cnt + CW'(1);
            else if (!last_row) r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Stage p0 -> p1: every write and strobe leaves the block registered
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1     <= 1'b0;
      addr_p1    <= '0;
      data_p1    <= '0;
      start_p1   <= 1'b0;
      res_vld_p1 <= 1'b0;
      res_p1     <= 1'b0;
    end else begin
      vld_p1     <= vld_p0;
      addr_p1    <= addr_cnt;
      data_p1    <= data_p0;
      start_p1   <= (state == START);
      res_vld_p1 <= (state == WAIT_DONE) && cascade_done_i;
      if ((state == WAIT_DONE) && cascade_done_i) res_p1 <= cascade_result_i;
    end
  end

  assign pix_rdy_o       = (state == ROW_PIX);
  assign busy_o          = (state != IDLE);
  assign ii_val_wr_o     = vld_p1;
  assign ii_addr_wr_o    = addr_p1;
  assign ii_data_wr_o    = {15'd0, data_p1};
  assign cascade_start_o = start_p1;
  assign result_val_o    = res_vld_p1;
  assign result_o        = res_p1;
  assign sum_o           = sum_acc;
  assign sq_sum_o        = sq_acc;

endmodule

// File: tb/tb_integral_image_window_writer.sv
// Scoreboard bench for integral_image_window_writer: constant-valued windows whose
// integral image is v*r*c, with stalls, ignored start requests and mid-window resets.
module tb_integral_image_window_writer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        win_start_i;
  logic [7:0]  pix_i;
  logic        pix_val_i;
  logic        pix_rdy_o;
  logic [8:0]  ii_addr_wr_o;
  logic [31:0] ii_data_wr_o;
  logic        ii_val_wr_o;
  logic        cascade_start_o;
  logic        cascade_done_i;
  logic        cascade_result_i;
  logic [16:0] sum_o;
  logic [24:0] sq_sum_o;
  logic        result_o;
  logic        result_val_o;
  logic        busy_o;

  integral_image_window_writer #(.WIN_SIZE(20), .ADDR_WIDTH_II(9)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .win_start_i(win_start_i),
    .pix_i(pix_i), .pix_val_i(pix_val_i), .pix_rdy_o(pix_rdy_o),
    .ii_addr_wr_o(ii_addr_wr_o), .ii_data_wr_o(ii_data_wr_o), .ii_val_wr_o(ii_val_wr_o),
    .cascade_start_o(cascade_start_o), .cascade_done_i(cascade_done_i),
    .cascade_result_i(cascade_result_i), .sum_o(sum_o), .sq_sum_o(sq_sum_o),
    .result_o(result_o), .result_val_o(result_val_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [8:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t exp_q[$];
  ent_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   wr_cnt = 0;
  int   start_cnt = 0;
  int   res_cnt = 0;
  logic res_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: event not observed within bound", name);
  endtask

  always @(negedge clk_i) begin
    if (ii_val_wr_o) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got addr %0d data %0d, expected none", ii_addr_wr_o, ii_data_wr_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(ii_addr_wr_o), 32'(mon_e.a));
        check("wr_data", ii_data_wr_o, mon_e.d);
      end
    end
    if (cascade_start_o) start_cnt++;
    if (result_val_o) begin
      res_cnt++;
      res_seen = result_o;
    end
    if (ii_val_wr_o || cascade_start_o || result_val_o)
      check("strobe_exclusive", 32'(ii_val_wr_o) + 32'(cascade_start_o) + 32'(result_val_o), 32'd1);
  end

  task automatic check_zero();
    check("rst_ii_val", 32'(ii_val_wr_o), 0);
    check("rst_ii_addr", 32'(ii_addr_wr_o), 0);
    check("rst_ii_data", ii_data_wr_o, 0);
    check("rst_start", 32'(cascade_start_o), 0);
    check("rst_res_val", 32'(result_val_o), 0);
    check("rst_result", 32'(result_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_pix_rdy", 32'(pix_rdy_o), 0);
    check("rst_sum", 32'(sum_o), 0);
    check("rst_sq_sum", 32'(sq_sum_o), 0);
  endtask

  // mode 0: full window; 1: reset once row 5 is being written; 2: reset in WAIT_DONE
  task automatic run_window(input logic [7:0] v, input bit toggle, input bit inject,
                            input int mode, input bit res);
    int  wb, sb, rb;
    bit  got;
    wb = wr_cnt; sb = start_cnt; rb = res_cnt;
    for (int r = 0; r <= 20; r++)
      for (int c = 0; c <= 20; c++)
        exp_q.push_back('{a: 9'(r*21 + c), d: 32'(int'(v) * r * c)});
    @(posedge clk_i); #1 win_start_i = 1'b1;
    @(posedge clk_i); #1 win_start_i = 1'b0;
    pix_i = v;
    got = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      pix_val_i   = toggle ? k[0] : 1'b1;
      win_start_i = inject && (k == 200);
      @(posedge clk_i); #1;
      if (cascade_start_o) begin got = 1'b1; break; end
      if (mode == 1 && (wr_cnt - wb) >= 120) break;
    end
    pix_val_i = 1'b0;
    win_start_i = 1'b0;
    if (mode == 1) begin
      check("row5_reached", 32'((wr_cnt - wb) >= 120), 1);
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      exp_q.delete();
      check_zero();
      return;
    end
    if (!got) begin
      fail_now("start_timeout");
      return;
    end
    if (mode == 2) begin
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      cascade_done_i = 1'b1; cascade_result_i = 1'b1;
      @(posedge clk_i); #1;
      cascade_done_i = 1'b0; cascade_result_i = 1'b0;
      repeat (4) @(posedge clk_i);
      #1;
      check("late_done_res_pulses", 32'(res_cnt - rb), 0);
      check("late_done_result", 32'(result_o), 0);
      check("late_done_busy", 32'(busy_o), 0);
      check("late_done_writes", 32'(wr_cnt - wb), 441);
      check("late_done_starts", 32'(start_cnt - sb), 1);
      return;
    end
    repeat (3) @(posedge clk_i);
    #1;
    if (inject) begin
      win_start_i = 1'b1;
      @(posedge clk_i); #1 win_start_i = 1'b0;
    end
    cascade_done_i = 1'b1; cascade_result_i = res;
    @(posedge clk_i); #1;
    cascade_done_i = 1'b0; cascade_result_i = 1'b0;
    for (int k = 0; k < 10 && res_cnt == rb; k++) begin
      @(posedge clk_i); #1;
    end
    if (res_cnt == rb) fail_now("result_timeout");
    repeat (3) @(posedge clk_i);
    #1;
    check("writes", 32'(wr_cnt - wb), 441);
    check("queue_empty", 32'(exp_q.size()), 0);
    check("start_pulses", 32'(start_cnt - sb), 1);
    check("result_pulses", 32'(res_cnt - rb), 1);
    check("result", 32'(res_seen), 32'(res));
    check("result_hold", 32'(result_o), 32'(res));
    check("sum", 32'(sum_o), 32'(int'(v) * 400));
    check("sq_sum", 32'(sq_sum_o), 32'(int'(v) * int'(v) * 400));
    check("idle_busy", 32'(busy_o), 0);
  endtask

  initial begin
    rst_i = 1'b1; win_start_i = 1'b0; pix_i = '0; pix_val_i = 1'b0;
    cascade_done_i = 1'b0; cascade_result_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    check_zero();

    run_window(8'd0,   1'b0, 1'b0, 0, 1'b1);
    run_window(8'd1,   1'b0, 1'b1, 0, 1'b0);
    run_window(8'd255, 1'b0, 1'b0, 0, 1'b1);
    run_window(8'd1,   1'b1, 1'b0, 0, 1'b1);
    run_window(8'd1,   1'b0, 1'b0, 1, 1'b0);
    run_window(8'd1,   1'b0, 1'b0, 0, 1'b1);
    run_window(8'd0,   1'b0, 1'b0, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/integral_image_window_writer.md
INTEGRAL_IMAGE_WINDOW_WRITER -- requirements
Module: integral_image_window_writer

Interface
REQ-001 SHALL have parameter WIN_SIZE, default 20, pixel window edge length.
REQ-002 SHALL have parameter ADDR_WIDTH_II, default $clog2((WIN_SIZE+1)*(WIN_SIZE+1)) = 9, integral-image write address width.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic rising-edge.
REQ-004 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-005 SHALL have port win_start_i, input, 1, one-cycle request to begin a new window.
REQ-006 SHALL have port pix_i, input, 8, pixel, raster order, row-major.
REQ-007 SHALL have port pix_val_i, input, 1, pix_i valid.
REQ-008 SHALL have port pix_rdy_o, output, 1, block accepts pixel this cycle.
REQ-009 SHALL have port ii_addr_wr_o, output, ADDR_WIDTH_II, integral-image word address to cascade.
REQ-010 SHALL have port ii_data_wr_o, output, 32, integral-image word, zero-extended.
REQ-011 SHALL have port ii_val_wr_o, output, 1, write strobe, one word per high cycle.
REQ-012 SHALL have port cascade_start_o, output, 1, one-cycle start pulse to cascade.
REQ-013 SHALL have port cascade_done_i, input, 1, cascade finished.
REQ-014 SHALL have port cascade_result_i, input, 1, cascade pass/fail, valid while cascade_done_i high.
REQ-015 SHALL have ports sum_o (17 bits) and sq_sum_o (25 bits), outputs, window pixel sum and sum of squares for variance computation.
REQ-016 SHALL have ports result_o (1), result_val_o (1), busy_o (1), outputs: captured result, one-cycle result strobe, window in progress.

Function
REQ-017 SHALL implement FSM states IDLE, ZERO_ROW, ROW_COL0, ROW_PIX, START, WAIT_DONE.
REQ-018 IDLE -> ZERO_ROW on win_start_i; win_start_i SHALL be ignored in every other state.
REQ-019 ZERO_ROW SHALL write data 0 to addresses 0..WIN_SIZE, one per cycle, then go to ROW_COL0 with row r=1.
REQ-020 ROW_COL0 SHALL write data 0 to address r*(WIN_SIZE+1) in one cycle, clear the row accumulator, then go to ROW_PIX with c=1.
REQ-021 pix_rdy_o SHALL be high only in ROW_PIX; a pixel is accepted when pix_val_i && pix_rdy_o.
REQ-022 For each accepted pixel at (r,c): rowsum += pix; ii[r][c] = rowsum + ii[r-1][c] (ii[0][*]=0), held in a WIN_SIZE+1 entry previous-row line buffer updated in place.
REQ-023 The write for an accepted pixel SHALL appear on ii_*_wr_o exactly one cycle after acceptance at address r*(WIN_SIZE+1)+c.
REQ-024 Cycles without acceptance in ROW_PIX SHALL produce no write and no state change (backpressure stalls freely).
REQ-025 After c=WIN_SIZE: r<WIN_SIZE -> ROW_COL0 with r+1; r=WIN_SIZE -> START.
REQ-026 START SHALL assert cascade_start_o for exactly one cycle, occurring after the final write's strobe cycle, then go to WAIT_DONE.
REQ-027 WAIT_DONE on cascade_done_i SHALL register cascade_result_i into result_o, pulse result_val_o one cycle later for one cycle, return to IDLE.
REQ-028 sum_o and sq_sum_o SHALL accumulate every accepted pixel (pix, pix*pix), clear on leaving IDLE, and hold until next window start; no overflow possible (max 102000, 26010000).
REQ-029 Exactly (WIN_SIZE+1)^2 = 441 writes SHALL occur per window, each address once, ascending order.
REQ-030 busy_o SHALL be high in every state except IDLE.
REQ-031 ii_val_wr_o, cascade_start_o, result_val_o SHALL never be high in the same cycle.

Reset
REQ-032 rst_i high SHALL, on the next clock edge, force IDLE, counters/accumulators/line buffer to 0, and all outputs to 0, including mid-window or in WAIT_DONE.
REQ-033 A cascade_done_i arriving after a reset mid-WAIT_DONE SHALL be ignored.

Verification
REQ-034 All pixels 0, done_i with result_i=1 -> 441 writes all data 0, one start pulse, result_o=1, result_val_o one pulse.
REQ-035 All pixels 1 -> word at addr r*21+c = r*c; addr 440 data 400; sum_o=400, sq_sum_o=400.
REQ-036 All pixels 255 -> addr 440 data 102000; sum_o=102000; sq_sum_o=26010000.
REQ-037 pix_val_i toggled every other cycle -> identical write sequence to REQ-035, no writes in stall cycles.
REQ-038 rst_i asserted during row 5 then new window of 1s -> all outputs 0 after reset; second window matches REQ-035 exactly.
REQ-039 win_start_i pulsed during ROW_PIX and WAIT_DONE -> ignored; exactly one start pulse per window.
